// File: rtl/cpu_exec_core.sv
// cpu_exec_core: execution slice of the 8-bit microprocessor.
// Holds the instruction decoder, an ALU with a registered result and
// flags, and the data-memory address/write-data multiplexer.
// Optional build macro ALU_ROTATE_EN: opcodes 7/8 become ROL/ROR instead
// of the logical shifts SHL/SHR.
module cpu_exec_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        inst,
    input  logic [DATA_W-1:0] alu_a,
    input  logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] r0_data,
    input  logic              mem_write_tb,
    input  logic              mem_read_tb,
    input  logic [ADDR_W-1:0] access_addr_tb,
    input  logic [DATA_W-1:0] mem_write_data_tb,
    output logic [3:0]        opcode,
    output logic [1:0]        rd,
    output logic [1:0]        rs,
    output logic [1:0]        prevrd,
    output logic              mem_read,
    output logic              mem_write,
    output logic              reg_write,
    output logic [DATA_W-1:0] immediate_value,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] flag,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data
);

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_AND   = 4'h3,
        OP_OR    = 4'h4,
        OP_XOR   = 4'h5,
        OP_NOT   = 4'h6,
        OP_SHL   = 4'h7,
        OP_SHR   = 4'h8,
        OP_ADDI  = 4'h9,
        OP_MOVI  = 4'hA,
        OP_LOAD  = 4'hB,
        OP_STORE = 4'hC,
        OP_CMP   = 4'hD,
        OP_INC   = 4'hE,
        OP_DEC   = 4'hF
    } opcode_t;

    opcode_t           w_op;
    logic [DATA_W-1:0] w_imm;
    logic [1:0]        w_rd;
    logic              w_regWrite;

    logic [DATA_W:0]   w_ext;
    logic [DATA_W-1:0] w_res;
    logic              w_carry;
    logic              w_ovf;
    logic              w_updRes;
    logic              w_updFlag;
    logic [DATA_W-1:0] w_flagNext;

    logic [DATA_W-1:0] r_aluResult;
    logic [DATA_W-1:0] r_flag;
    logic [1:0]        r_prevrd;

    assign w_op  = opcode_t'(inst[7:4]);
    assign w_imm = {{(DATA_W-4){1'b0}}, inst[3:0]};

    // Decode: immediate and memory opcodes always target R0; strobes are
    // suppressed while reset is held low.
    always_comb begin
        w_rd       = inst[3:2];
        w_regWrite = 1'b1;
        case (w_op)
            OP_ADDI, OP_MOVI, OP_LOAD, OP_STORE: w_rd = 2'b00;
            default: ;
        endcase
        case (w_op)
            OP_NOP, OP_STORE, OP_CMP: w_regWrite = 1'b0;
            default: ;
        endcase
    end

    assign opcode          = inst[7:4];
    assign rd              = w_rd;
    assign rs              = inst[1:0];
    assign immediate_value = w_imm;
    assign mem_read        = reset & (w_op == OP_LOAD);
    assign mem_write       = reset & (w_op == OP_STORE);
    assign reg_write       = reset & w_regWrite;

    // ALU: next result, carry/borrow and signed overflow for the current opcode.
    always_comb begin
        w_ext     = '0;
        w_res     = r_aluResult;
        w_carry   = 1'b0;
        w_ovf     = 1'b0;
        w_updRes  = 1'b1;
        w_updFlag = 1'b1;
        case (w_op)
            OP_ADD: begin
                w_ext   = {1'b0, alu_a} + {1'b0, alu_b};
                w_res   = w_ext[DATA_W-1:0];
                w_carry = w_ext[DATA_W];
                w_ovf   = (alu_a[7] == alu_b[7]) && (w_res[7] != alu_a[7]);
            end
            OP_ADDI: begin
                w_ext   = {1'b0, alu_a} + {1'b0, w_imm};
                w_res   = w_ext[DATA_W-1:0];
                w_carry = w_ext[DATA_W];
                w_ovf   = !alu_a[7] && w_res[7];
            end
            OP_INC: begin
                w_ext   = {1'b0, alu_a} + 9'd1;
                w_res   = w_ext[DATA_W-1:0];
                w_carry = w_ext[DATA_W];
                w_ovf   = !alu_a[7] && w_res[7];
            end
            OP_SUB, OP_CMP: begin
                w_ext    = {1'b0, alu_a} - {1'b0, alu_b};
                w_res    = w_ext[DATA_W-1:0];
                w_carry  = w_ext[DATA_W];
                w_ovf    = (alu_a[7] != alu_b[7]) && (w_res[7] != alu_a[7]);
                w_updRes = (w_op == OP_SUB);
            end
            OP_DEC: begin
                w_ext   = {1'b0, alu_a} - 9'd1;
                w_res   = w_ext[DATA_W-1:0];
                w_carry = w_ext[DATA_W];
                w_ovf   = alu_a[7] && !w_res[7];
            end
            OP_AND: w_res = alu_a & alu_b;
            OP_OR:  w_res = alu_a | alu_b;
            OP_XOR: w_res = alu_a ^ alu_b;
            OP_NOT: w_res = ~alu_a;
`ifdef ALU_ROTATE_EN
            OP_SHL: begin
                w_res   = {alu_a[6:0], alu_a[7]};
                w_carry = alu_a[7];
            end
            OP_SHR: begin
                w_res   = {alu_a[0], alu_a[7:1]};
                w_carry = alu_a[0];
            end
`else
            OP_SHL: begin
                w_res   = {alu_a[6:0], 1'b0};
                w_carry = alu_a[7];
            end
            OP_SHR: begin
                w_res   = {1'b0, alu_a[7:1]};
                w_carry = alu_a[0];
            end
`endif
            OP_MOVI: w_res = w_imm;
            default: begin
                w_updRes  = 1'b0;
                w_updFlag = 1'b0;
            end
        endcase
    end

    assign w_flagNext = {3'b000, ~^w_res, w_ovf, w_res[7], w_carry, (w_res == '0)};

    // Result, flag and previous-rd registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_aluResult <= '0;
            r_flag      <= '0;
            r_prevrd    <= 2'b00;
        end else begin
            r_prevrd <= w_rd;
            if (w_updRes) begin
                r_aluResult <= w_res;
            end
            if (w_updFlag) begin
                r_flag <= w_flagNext;
            end
        end
    end

    assign alu_result = r_aluResult;
    assign flag       = r_flag;
    assign prevrd     = r_prevrd;

    // Data-transfer mux: bench load mode wins, then bench readback, then the
    // instruction immediate addresses memory with R0 as store data.
    always_comb begin
        mem_access_addr = inst[3:0];
        mem_write_data  = r0_data;
        if (mem_write_tb) begin
            mem_access_addr = access_addr_tb;
            mem_write_data  = mem_write_data_tb;
        end else if (mem_read_tb) begin
            mem_access_addr = access_addr_tb;
        end
    end

endmodule

// File: tb/tb_cpu_exec_core.sv
// Testbench for cpu_exec_core: directed steps from the test plan followed by
// randomized instructions compared against an arithmetic reference model.
module tb_cpu_exec_core;

    logic       clk;
    logic       reset;
    logic [7:0] inst;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] r0_data;
    logic       mem_write_tb;
    logic       mem_read_tb;
    logic [3:0] access_addr_tb;
    logic [7:0] mem_write_data_tb;
    logic [3:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [1:0] prevrd;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [7:0] immediate_value;
    logic [7:0] alu_result;
    logic [7:0] flag;
    logic [3:0] mem_access_addr;
    logic [7:0] mem_write_data;

    int passCount  = 0;
    int checkCount = 0;

    int mResult = 0;
    int mFlag   = 0;
    int mPrevrd = 0;

    cpu_exec_core dut (
        .clk(clk), .reset(reset), .inst(inst), .alu_a(alu_a), .alu_b(alu_b),
        .r0_data(r0_data), .mem_write_tb(mem_write_tb), .mem_read_tb(mem_read_tb),
        .access_addr_tb(access_addr_tb), .mem_write_data_tb(mem_write_data_tb),
        .opcode(opcode), .rd(rd), .rs(rs), .prevrd(prevrd), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .immediate_value(immediate_value),
        .alu_result(alu_result), .flag(flag), .mem_access_addr(mem_access_addr),
        .mem_write_data(mem_write_data)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports a FAIL line on mismatch.
    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    endtask

    function automatic int expRd(input int i);
        int op = i / 16;
        if (op >= 9 && op <= 12) return 0;
        return (i / 4) % 4;
    endfunction

    function automatic int toSigned(input int v);
        return (v > 127) ? v - 256 : v;
    endfunction

    // Decode and data-transfer expectations for the inputs currently applied.
    task automatic checkComb();
        int i, op, wr, addrExp, dataExp;
        i  = inst;
        op = i / 16;
        wr = ((op >= 1 && op <= 11) || op >= 14) ? 1 : 0;
        if (mem_write_tb) begin
            addrExp = access_addr_tb;
            dataExp = mem_write_data_tb;
        end else if (mem_read_tb) begin
            addrExp = access_addr_tb;
            dataExp = r0_data;
        end else begin
            addrExp = i % 16;
            dataExp = r0_data;
        end
        checkOutput("opcode", 8'(opcode), 8'(op));
        checkOutput("rd", 8'(rd), 8'(expRd(i)));
        checkOutput("rs", 8'(rs), 8'(i % 4));
        checkOutput("imm", immediate_value, 8'(i % 16));
        checkOutput("mem_read", 8'(mem_read), 8'((reset && op == 11) ? 1 : 0));
        checkOutput("mem_write", 8'(mem_write), 8'((reset && op == 12) ? 1 : 0));
        checkOutput("reg_write", 8'(reg_write), 8'(reset ? wr : 0));
        checkOutput("mem_addr", 8'(mem_access_addr), 8'(addrExp));
        checkOutput("mem_wdata", mem_write_data, 8'(dataExp));
    endtask

    // Reference model for one rising edge, using integer arithmetic.
    task automatic modelEdge();
        int op, a, b, imm, r, r8, c, sv, v, hasV, z, n, p;
        if (!reset) begin
            mResult = 0;
            mFlag   = 0;
            mPrevrd = 0;
            return;
        end
        op = inst / 16;
        a = alu_a; b = alu_b; imm = inst % 16;
        r = mResult; c = 0; sv = 0; hasV = 0;
        case (op)
            1:  begin r = a + b;   c = (r > 255);  sv = toSigned(a) + toSigned(b); hasV = 1; end
            2, 13: begin r = a - b; c = (a < b);  sv = toSigned(a) - toSigned(b); hasV = 1; end
            3:  r = a & b;
            4:  r = a | b;
            5:  r = a ^ b;
            6:  r = 255 - a;
`ifdef ALU_ROTATE_EN
            7:  begin r = (a * 2) % 256 + a / 128; c = a / 128; end
            8:  begin r = a / 2 + (a % 2) * 128;   c = a % 2; end
`else
            7:  begin r = a * 2; c = a / 128; end
            8:  begin r = a / 2; c = a % 2; end
`endif
            9:  begin r = a + imm; c = (r > 255); sv = toSigned(a) + imm; hasV = 1; end
            10: r = imm;
            14: begin r = a + 1; c = (r > 255); sv = toSigned(a) + 1; hasV = 1; end
            15: begin r = a - 1; c = (a < 1);   sv = toSigned(a) - 1; hasV = 1; end
            default: ;
        endcase
        r8 = ((r % 256) + 256) % 256;
        v  = (hasV && (sv > 127 || sv < -128)) ? 1 : 0;
        z  = (r8 == 0);
        n  = r8 / 128;
        p  = ($countones(8'(r8)) % 2 == 0) ? 1 : 0;
        if (!(op == 0 || op == 11 || op == 12 || op == 13)) mResult = r8;
        if (!(op == 0 || op == 11 || op == 12)) mFlag = z + 2 * c + 4 * n + 8 * v + 16 * p;
        mPrevrd = expRd(inst);
    endtask

    // Applies one cycle of inputs, checks decode, clocks, then checks registers.
    task automatic applyStimulus(input logic rst, input logic [7:0] i, input logic [7:0] a,
                                 input logic [7:0] b, input logic [7:0] r0, input logic wtb,
                                 input logic rtb, input logic [3:0] addr, input logic [7:0] wdata);
        @(negedge clk);
        reset = rst; inst = i; alu_a = a; alu_b = b; r0_data = r0;
        mem_write_tb = wtb; mem_read_tb = rtb; access_addr_tb = addr; mem_write_data_tb = wdata;
        #1;
        checkComb();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("alu_result", alu_result, 8'(mResult));
        checkOutput("flag", flag, 8'(mFlag));
        checkOutput("prevrd", 8'(prevrd), 8'(mPrevrd));
    endtask

    initial begin
        reset = 1'b0; inst = 8'h1F; alu_a = '0; alu_b = '0; r0_data = '0;
        mem_write_tb = 1'b0; mem_read_tb = 1'b0; access_addr_tb = '0; mem_write_data_tb = '0;

        // Reset held for two edges.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 8'h1F, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
            checkOutput("rst_result", alu_result, 8'h00);
            checkOutput("rst_flag", flag, 8'h00);
            checkOutput("rst_prevrd", 8'(prevrd), 8'h00);
            checkOutput("rst_regwrite", 8'(reg_write), 8'h00);
        end

        // ADD 0xFF + 0x01 wraps to zero with carry.
        applyStimulus(1'b1, 8'h16, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        checkOutput("add_result", alu_result, 8'h00);
        checkOutput("add_flag", flag, 8'h13);
        checkOutput("add_regwrite", 8'(reg_write), 8'h01);

        // CMP 5 - 7 updates flags only.
        applyStimulus(1'b1, 8'hD6, 8'h05, 8'h07, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        checkOutput("cmp_result", alu_result, 8'h00);
        checkOutput("cmp_flag", flag, 8'h06);
        checkOutput("cmp_regwrite", 8'(reg_write), 8'h00);

        // MOVI 9, then shift/rotate left of 0x81.
        applyStimulus(1'b1, 8'hA9, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        checkOutput("movi_rd", 8'(rd), 8'h00);
        checkOutput("movi_result", alu_result, 8'h09);
        applyStimulus(1'b1, 8'h73, 8'h81, 8'h00, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
`ifdef ALU_ROTATE_EN
        checkOutput("shl_result", alu_result, 8'h03);
`else
        checkOutput("shl_result", alu_result, 8'h02);
`endif
        checkOutput("shl_carry", 8'(flag[1]), 8'h01);

        // STORE through R0, then bench load mode overrides the mux.
        applyStimulus(1'b1, 8'hC5, 8'h00, 8'h00, 8'h3C, 1'b0, 1'b0, 4'h0, 8'h00);
        checkOutput("st_memwrite", 8'(mem_write), 8'h01);
        checkOutput("st_addr", 8'(mem_access_addr), 8'h05);
        checkOutput("st_data", mem_write_data, 8'h3C);
        applyStimulus(1'b1, 8'hC5, 8'h00, 8'h00, 8'h3C, 1'b1, 1'b0, 4'hA, 8'h77);
        checkOutput("tb_addr", 8'(mem_access_addr), 8'h0A);
        checkOutput("tb_data", mem_write_data, 8'h77);

        // LOAD from address 2.
        applyStimulus(1'b1, 8'hB2, 8'h00, 8'h00, 8'h3C, 1'b0, 1'b0, 4'h0, 8'h00);
        checkOutput("ld_memread", 8'(mem_read), 8'h01);
        checkOutput("ld_regwrite", 8'(reg_write), 8'h01);
        checkOutput("ld_addr", 8'(mem_access_addr), 8'h02);
        checkOutput("ld_prevrd", 8'(prevrd), 8'h00);

        // Mid-program reset clears the registers regardless of instruction.
        applyStimulus(1'b1, 8'h9F, 8'h80, 8'h00, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        applyStimulus(1'b0, 8'hEC, 8'h7F, 8'h00, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        checkOutput("midrst_result", alu_result, 8'h00);

        // Randomized instruction stream.
        for (int k = 0; k < 400; k++) begin
            applyStimulus(($urandom_range(0, 15) != 0), 8'($urandom), 8'($urandom), 8'($urandom),
                          8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                          4'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
